pt_fetcher: RTL and testbench

PT_FETCHER -- requirements
Module: pt_fetcher

---
 rtl/pt_fetcher_pkg.sv | 48 ++++
 rtl/pt_fetcher.sv | 206 ++++++++++++++++++++
 tb/tb_pt_fetcher.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pt_fetcher_pkg.sv
// -----------------------------------------------------------------------------
// pt_fetcher_pkg
//   Shared geometry defines for the pixel-transform fetch path, plus the
//   half-word merge helper used by pt_fetcher.
//
//   The `LOG_* defines are the shared params.v set: coordinate widths, the
//   truncated pixel width and the memory word width. They are guarded so that
//   a project-wide definition takes precedence. `LOG_MEM must be exactly
//   twice `LOG_TRUNC, because two pixels share one memory word.
//
//   Contents:
//     PIX_W, MEM_W, X_W, Y_W : widths derived from the shared defines
//     merge_half()           : replace one pixel half of a memory word
// -----------------------------------------------------------------------------
`ifndef LOG_WIDTH
`define LOG_WIDTH 10
`endif
`ifndef LOG_HEIGHT
`define LOG_HEIGHT 9
`endif
`ifndef LOG_TRUNC
`define LOG_TRUNC 18
`endif
`ifndef LOG_MEM
`define LOG_MEM 36
`endif

package pt_fetcher_pkg;

  localparam int PIX_W = `LOG_TRUNC;
  localparam int MEM_W = `LOG_MEM;
  localparam int X_W   = `LOG_WIDTH;
  localparam int Y_W   = `LOG_HEIGHT;

  // Even x lives in the upper half of the word, odd x in the lower half.
  // The half that is not selected passes through unchanged.
  function automatic logic [MEM_W-1:0] merge_half(
    input logic [MEM_W-1:0] word,
    input logic             odd,
    input logic [PIX_W-1:0] pix
  );
    logic [MEM_W-1:0] res;
    if (odd) res = {word[MEM_W-1:PIX_W], pix};
    else     res = {pix, word[PIX_W-1:0]};
    return res;
  endfunction

endpackage

// File: rtl/pt_fetcher.sv
// -----------------------------------------------------------------------------
// pt_fetcher
//   Read-modify-write engine that writes single transformed pixels into a
//   memory that stores two pixels per word. Each accepted pixel request causes
//   one read of the containing word, then one write of the same word with the
//   selected half replaced.
//
//   Optional feature (macro PTF_COALESCE_EN): while a write is waiting for its
//   grant, one request for the partner pixel of the same word (same y, x that
//   differs only in bit 0) is folded into the pending write.
//
// Parameters
//   READ_LATENCY : cycles from the read grant edge to a valid ptf_pixel_read (>=1)
//
// Ports
//   clock           in   system clock, rising edge
//   reset           in   synchronous active-high reset
//   frame_flag      in   frame boundary pulse; abandons any in-flight pixel
//   pt_flag         in   pixel request valid (held until done_pt)
//   pt_x, pt_y      in   pixel coordinates
//   pt_pixel        in   pixel value
//   done_pt         out  combinational accept of the current pixel request
//   ptf_flag        out  memory request valid (registered)
//   ptf_wr          out  1 = write, 0 = read (registered)
//   ptf_x, ptf_y    out  memory request coordinates (registered)
//   ptf_pixel_write out  write word (registered)
//   done_ptf        in   combinational grant of the memory request
//   ptf_pixel_read  in   read word, valid READ_LATENCY edges after the grant
// -----------------------------------------------------------------------------
module pt_fetcher
  import pt_fetcher_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  frame_flag,
  input  logic                  pt_flag,
  input  logic [`LOG_WIDTH-1:0] pt_x,
  input  logic [`LOG_HEIGHT-1:0] pt_y,
  input  logic [`LOG_TRUNC-1:0] pt_pixel,
  output logic                  done_pt,
  output logic                  ptf_flag,
  output logic                  ptf_wr,
  output logic [`LOG_WIDTH-1:0] ptf_x,
  output logic [`LOG_HEIGHT-1:0] ptf_y,
  output logic [`LOG_MEM-1:0]   ptf_pixel_write,
  input  logic                  done_ptf,
  input  logic [`LOG_MEM-1:0]   ptf_pixel_read
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_REQ  = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;
  localparam logic [1:0] ST_WR_REQ  = 2'd3;

  localparam int CNT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [PIX_W-1:0]      pix_q, pix_d;
  logic                  flag_q, flag_d;
  logic                  wr_q, wr_d;
  logic [MEM_W-1:0]      wdata_q, wdata_d;
  logic                  accept;
`ifdef PTF_COALESCE_EN
  logic                  coal_q, coal_d;
  logic                  coal_hit;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    pix_d   = pix_q;
    flag_d  = flag_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    accept  = 1'b0;
`ifdef PTF_COALESCE_EN
    coal_d   = coal_q;
    coal_hit = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pt_flag && !frame_flag) begin
          accept  = 1'b1;
          x_d     = pt_x;
          y_d     = pt_y;
          pix_d   = pt_pixel;
          flag_d  = 1'b1;
          wr_d    = 1'b0;
          state_d = ST_RD_REQ;
        end
      end

      ST_RD_REQ: begin
        if (done_ptf) begin
          flag_d  = 1'b0;
          // Counting down to zero lands the sample exactly READ_LATENCY
          // edges after the grant edge.
          cnt_d   = CNT_W'(READ_LATENCY - 1);
          state_d = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          wdata_d = merge_half(ptf_pixel_read, x_q[0], pix_q);
          flag_d  = 1'b1;
          wr_d    = 1'b1;
          state_d = ST_WR_REQ;
`ifdef PTF_COALESCE_EN
          coal_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_WR_REQ: begin
        if (done_ptf) begin
          flag_d  = 1'b0;
          wr_d    = 1'b0;
          state_d = ST_IDLE;
        end
`ifdef PTF_COALESCE_EN
        // Partner pixel of the pending word: fold it in while the write
        // still waits. Only one fold per word so the write cannot starve.
        else if (!frame_flag && !coal_q && pt_flag &&
                 (pt_y == y_q) &&
                 (pt_x[X_W-1:1] == x_q[X_W-1:1]) &&
                 (pt_x[0] != x_q[0])) begin
          coal_hit = 1'b1;
          wdata_d  = merge_half(wdata_q, pt_x[0], pt_pixel);
          coal_d   = 1'b1;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
        flag_d  = 1'b0;
        wr_d    = 1'b0;
      end
    endcase

    // Frame boundary wins over grants and requests: drop the in-flight pixel.
    if (frame_flag) begin
      state_d = ST_IDLE;
      flag_d  = 1'b0;
      wr_d    = 1'b0;
    end
  end

`ifdef PTF_COALESCE_EN
  assign done_pt = (accept || coal_hit) && !reset;
`else
  assign done_pt = accept && !reset;
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pix_q   <= '0;
      flag_q  <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
`ifdef PTF_COALESCE_EN
      coal_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pix_q   <= pix_d;
      flag_q  <= flag_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
`ifdef PTF_COALESCE_EN
      coal_q  <= coal_d;
`endif
    end
  end

  assign ptf_flag        = flag_q;
  assign ptf_wr          = wr_q;
  assign ptf_x           = x_q;
  assign ptf_y           = y_q;
  assign ptf_pixel_write = wdata_q;

endmodule

// File: tb/tb_pt_fetcher.sv
// -----------------------------------------------------------------------------
// tb_pt_fetcher
//   Directed bench for pt_fetcher with READ_LATENCY = 2. The bench plays the
//   memory: it drives done_ptf by hand and holds a fixed read word.
//   Read word halves: upper 18'h2AAAA, lower 18'h3BBBB (18-bit halves).
// -----------------------------------------------------------------------------
module tb_pt_fetcher;

  localparam int PW = `LOG_TRUNC;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   frame_flag;
  logic                   pt_flag;
  logic [`LOG_WIDTH-1:0]  pt_x;
  logic [`LOG_HEIGHT-1:0] pt_y;
  logic [`LOG_TRUNC-1:0]  pt_pixel;
  logic                   done_pt;
  logic                   ptf_flag;
  logic                   ptf_wr;
  logic [`LOG_WIDTH-1:0]  ptf_x;
  logic [`LOG_HEIGHT-1:0] ptf_y;
  logic [`LOG_MEM-1:0]    ptf_pixel_write;
  logic                   done_ptf;
  logic [`LOG_MEM-1:0]    ptf_pixel_read;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [PW-1:0] HI_RD = 18'h2AAAA;
  localparam logic [PW-1:0] LO_RD = 18'h3BBBB;

  pt_fetcher #(.READ_LATENCY(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .frame_flag     (frame_flag),
    .pt_flag        (pt_flag),
    .pt_x           (pt_x),
    .pt_y           (pt_y),
    .pt_pixel       (pt_pixel),
    .done_pt        (done_pt),
    .ptf_flag       (ptf_flag),
    .ptf_wr         (ptf_wr),
    .ptf_x          (ptf_x),
    .ptf_y          (ptf_y),
    .ptf_pixel_write(ptf_pixel_write),
    .done_ptf       (done_ptf),
    .ptf_pixel_read (ptf_pixel_read)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset          = 1'b1;
    frame_flag     = 1'b0;
    pt_flag        = 1'b0;
    pt_x           = '0;
    pt_y           = '0;
    pt_pixel       = '0;
    done_ptf       = 1'b0;
    ptf_pixel_read = {HI_RD, LO_RD};

    // Reset state
    cyc(); cyc(); mid();
    chk("rst_flag", 64'(ptf_flag), 64'd0);
    chk("rst_wr",   64'(ptf_wr),   64'd0);
    chk("rst_x",    64'(ptf_x),    64'd0);
    chk("rst_y",    64'(ptf_y),    64'd0);
    chk("rst_wdat", 64'(ptf_pixel_write), 64'd0);
    chk("rst_done", 64'(done_pt),  64'd0);
    cyc();
    reset = 1'b0;

    // Even pixel: x=4, y=3 replaces the upper half
    pt_flag = 1'b1; pt_x = 4; pt_y = 3; pt_pixel = 18'h12345;
    mid();
    chk("t1_done_idle", 64'(done_pt), 64'd1);
    chk("t1_flag_idle", 64'(ptf_flag), 64'd0);
    cyc();
    pt_flag = 1'b0;
    mid();
    chk("t1_rd_flag", 64'(ptf_flag), 64'd1);
    chk("t1_rd_wr",   64'(ptf_wr),   64'd0);
    chk("t1_rd_x",    64'(ptf_x),    64'd4);
    chk("t1_rd_y",    64'(ptf_y),    64'd3);
    chk("t1_done_once", 64'(done_pt), 64'd0);
    done_ptf = 1'b1;
    cyc();
    done_ptf = 1'b0;
    mid();
    chk("t1_wait_flag0", 64'(ptf_flag), 64'd0);
    cyc(); mid();
    chk("t1_wait_flag1", 64'(ptf_flag), 64'd0);
    cyc(); mid();
    chk("t1_wr_flag", 64'(ptf_flag), 64'd1);
    chk("t1_wr_wr",   64'(ptf_wr),   64'd1);
    chk("t1_wr_word", 64'(ptf_pixel_write), 64'({18'h12345, LO_RD}));
    done_ptf = 1'b1;
    cyc();
    done_ptf = 1'b0;
    mid();
    chk("t1_end_flag", 64'(ptf_flag), 64'd0);
    chk("t1_end_wr",   64'(ptf_wr),   64'd0);

    // Frame pulse in IDLE blocks acceptance
    cyc();
    frame_flag = 1'b1;
    pt_flag = 1'b1; pt_x = 5; pt_y = 7; pt_pixel = 18'h12345;
    mid();
    chk("fr_idle_done", 64'(done_pt), 64'd0);
    cyc();
    frame_flag = 1'b0;
    mid();
    chk("fr_idle_noreq", 64'(ptf_flag), 64'd0);
    chk("t2_done_idle", 64'(done_pt), 64'd1);

    // Odd pixel: x=5 with read grant held off for 5 cycles
    cyc();
    pt_x = 9; pt_pixel = 18'h00777;   // next request waits behind this one
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("t2_hold_flag", 64'(ptf_flag), 64'd1);
      chk("t2_hold_wr",   64'(ptf_wr),   64'd0);
      chk("t2_hold_x",    64'(ptf_x),    64'd5);
      chk("t2_hold_y",    64'(ptf_y),    64'd7);
      chk("t2_hold_done", 64'(done_pt),  64'd0);
      cyc();
    end
    done_ptf = 1'b1;
    mid();
    chk("t2_grant_flag", 64'(ptf_flag), 64'd1);
    cyc();
    done_ptf = 1'b0;
    pt_flag  = 1'b0;
    cyc(); cyc(); mid();
    chk("t2_wr_flag", 64'(ptf_flag), 64'd1);
    chk("t2_wr_wr",   64'(ptf_wr),   64'd1);
    chk("t2_wr_word", 64'(ptf_pixel_write), 64'({HI_RD, 18'h12345}));
    done_ptf = 1'b1;
    cyc();
    done_ptf = 1'b0;
    mid();
    chk("t2_end_flag", 64'(ptf_flag), 64'd0);

    // Frame pulse during RD_WAIT discards the pixel
    pt_flag = 1'b1; pt_x = 2; pt_y = 1; pt_pixel = 18'h00003;
    #1;
    chk("t3_done_idle", 64'(done_pt), 64'd1);
    cyc();
    pt_flag  = 1'b0;
    done_ptf = 1'b1;
    mid();
    chk("t3_rd_flag", 64'(ptf_flag), 64'd1);
    cyc();
    done_ptf   = 1'b0;
    frame_flag = 1'b1;
    mid();
    chk("t3_fr_flag", 64'(ptf_flag), 64'd0);
    chk("t3_fr_done", 64'(done_pt),  64'd0);
    cyc();
    frame_flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("t3_nowrite_flag", 64'(ptf_flag), 64'd0);
      chk("t3_nowrite_wr",   64'(ptf_wr),   64'd0);
      cyc();
    end
    pt_flag = 1'b1; pt_x = 8; pt_y = 2; pt_pixel = 18'h0ABCD;
    mid();
    chk("t3_next_done", 64'(done_pt), 64'd1);
    cyc();
    pt_flag  = 1'b0;
    done_ptf = 1'b1;
    mid();
    chk("t3_next_flag", 64'(ptf_flag), 64'd1);
    chk("t3_next_x",    64'(ptf_x),    64'd8);
    cyc();
    done_ptf = 1'b0;
    cyc(); cyc(); mid();
    chk("t3_next_wr",   64'(ptf_wr), 64'd1);
    chk("t3_next_word", 64'(ptf_pixel_write), 64'({18'h0ABCD, LO_RD}));

    // Reset while in WR_REQ abandons the write
    reset = 1'b1;
    #1;
    chk("t4_rst_done", 64'(done_pt), 64'd0);
    cyc(); mid();
    chk("t4_flag", 64'(ptf_flag), 64'd0);
    chk("t4_wr",   64'(ptf_wr),   64'd0);
    chk("t4_x",    64'(ptf_x),    64'd0);
    chk("t4_y",    64'(ptf_y),    64'd0);
    chk("t4_word", 64'(ptf_pixel_write), 64'd0);
    chk("t4_done", 64'(done_pt),  64'd0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("t4_stay_flag", 64'(ptf_flag), 64'd0);
      cyc();
    end

    // Partner pixel arriving while the write waits for its grant
    pt_flag = 1'b1; pt_x = 4; pt_y = 3; pt_pixel = 18'h12345;
    mid();
    chk("t5_done_idle", 64'(done_pt), 64'd1);
    cyc();
    pt_flag  = 1'b0;
    done_ptf = 1'b1;
    cyc();
    done_ptf = 1'b0;
    cyc(); cyc(); mid();
    chk("t5_wr_flag", 64'(ptf_flag), 64'd1);
    chk("t5_wr_word", 64'(ptf_pixel_write), 64'({18'h12345, LO_RD}));
    pt_flag = 1'b1; pt_x = 5; pt_y = 3; pt_pixel = 18'h00001;
    #1;
`ifdef PTF_COALESCE_EN
    chk("t5_coal_done", 64'(done_pt), 64'd1);
    cyc();
    pt_x = 6; pt_pixel = 18'h00007;
    mid();
    chk("t5_x6_done", 64'(done_pt), 64'd0);
    chk("t5_coal_word", 64'(ptf_pixel_write), 64'({18'h12345, 18'h00001}));
    chk("t5_coal_flag", 64'(ptf_flag), 64'd1);
    pt_x = 5;
    #1;
    chk("t5_second_coal", 64'(done_pt), 64'd0);
`else
    chk("t5_nocoal_done", 64'(done_pt), 64'd0);
    cyc();
    pt_x = 6; pt_pixel = 18'h00007;
    mid();
    chk("t5_x6_done", 64'(done_pt), 64'd0);
    chk("t5_nocoal_word", 64'(ptf_pixel_write), 64'({18'h12345, LO_RD}));
    chk("t5_nocoal_flag", 64'(ptf_flag), 64'd1);
`endif
    pt_flag  = 1'b0;
    done_ptf = 1'b1;
    cyc();
    done_ptf = 1'b0;
    mid();
    chk("t5_end_flag", 64'(ptf_flag), 64'd0);
    pt_flag = 1'b1; pt_x = 6;
    #1;
    chk("t5_x6_idle_done", 64'(done_pt), 64'd1);
    pt_flag = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
